// File: rtl/bit_pair_collector_if.sv
// Bit-pair input channel and word output channel of bit_pair_collector.
// The master drives pairs and accepts words; the slave is the collector.
interface bit_pair_collector_if #(
  parameter int unsigned WIDTH = 8
);
  logic             bitEnable;
  logic             bitIn1;
  logic             bitIn2;
  logic             bitReady;
  logic [WIDTH-1:0] wordOut;
  logic             wordValid;
  logic             wordReady;

  modport master (
    output bitEnable, bitIn1, bitIn2, wordReady,
    input  bitReady, wordOut, wordValid
  );

  modport slave (
    input  bitEnable, bitIn1, bitIn2, wordReady,
    output bitReady, wordOut, wordValid
  );
endinterface

// File: rtl/bit_pair_collector.sv
// Packs enable-gated (bitIn1, bitIn2) pairs LSB-first into a WIDTH-bit word with valid/ready out.
// Define BPC_OVERRUN_EN to add the sticky overrun output for pairs dropped while full.
module bit_pair_collector #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef BPC_OVERRUN_EN
  output logic                 overrun,
`endif
  bit_pair_collector_if.slave  bus
);

  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StCollect, StFull} state_e;

  state_e           stateQ;
  logic [CntW-1:0]  pairCnt;
  logic [WIDTH-1:0] wordQ;
  logic             wordValidQ;
  logic             bitReadyQ;
  logic [WIDTH-1:0] pairMask;
  logic [WIDTH-1:0] pairData;

  // Place the incoming pair at bit position 2*pairCnt.
  assign pairMask = WIDTH'(2'b11) << {pairCnt, 1'b0};
  assign pairData = WIDTH'({bus.bitIn2, bus.bitIn1}) << {pairCnt, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= StCollect;
      pairCnt    <= '0;
      wordQ      <= '0;
      wordValidQ <= 1'b0;
      bitReadyQ  <= 1'b1;
    end else begin
      unique case (stateQ)
        StCollect: begin
          if (bus.bitEnable) begin
            wordQ <= (wordQ & ~pairMask) | pairData;
            if (pairCnt == CntW'(N - 1)) begin
              pairCnt    <= '0;
              stateQ     <= StFull;
              wordValidQ <= 1'b1;
              bitReadyQ  <= 1'b0;
            end else begin
              pairCnt <= pairCnt + 1'b1;
            end
          end
        end
        StFull: begin
          if (bus.wordReady) begin
            stateQ     <= StCollect;
            wordValidQ <= 1'b0;
            bitReadyQ  <= 1'b1;
          end
        end
        default: stateQ <= StCollect;
      endcase
    end
  end

`ifdef BPC_OVERRUN_EN
  logic overrunQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrunQ <= 1'b0;
    end else if (bus.bitEnable && !bitReadyQ) begin
      overrunQ <= 1'b1;
    end
  end

  assign overrun = overrunQ;
`else
  // Pairs offered while full are dropped without any indication.
`endif

  assign bus.wordOut   = wordQ;
  assign bus.wordValid = wordValidQ;
  assign bus.bitReady  = bitReadyQ;

endmodule
